// File: rtl/mmio_game_pkg.sv
// Shared offsets, bit indices and status type for the game MMIO register bank.
package mmio_game_pkg;

  localparam int STS_PENDING   = 0;
  localparam int STS_OVERFLOW  = 1;
  localparam int CTRL_FIRE     = 0;
  localparam int CTRL_TRAJ     = 1;
  localparam int CTRL_IRQ_MASK = 2;

  typedef struct packed {
    logic overflow;
    logic pending;
  } status_t;

  // Offsets beyond the target pairs are packed right after the 2N X/Y words.
  function automatic logic [5:0] ofs_vel(input int n);
    return 6'(2 * n);
  endfunction

  function automatic logic [5:0] ofs_ang(input int n);
    return 6'(2 * n + 1);
  endfunction

  function automatic logic [5:0] ofs_status(input int n);
    return 6'(2 * n + 2);
  endfunction

  function automatic logic [5:0] ofs_ctrl(input int n);
    return 6'(2 * n + 3);
  endfunction

  function automatic logic [5:0] ofs_traj(input int n);
    return 6'(2 * n + 4);
  endfunction

endpackage

// File: rtl/mmio_event_latch.sv
// Rising-edge event capture with sticky PENDING/OVERFLOW, two snapshot words
// and a clear-on-read input.
module mmio_event_latch
  import mmio_game_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         event_i,
  input  logic         clear_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output status_t      status_o,
  output logic [W-1:0] snap_a_o,
  output logic [W-1:0] snap_b_o
);

  // Resets to "not seen low", so a level held through reset cannot re-trigger.
  logic         low_seen_q;
  logic         rise;
  status_t      status_q, status_d;
  logic [W-1:0] snap_a_q, snap_a_d;
  logic [W-1:0] snap_b_q, snap_b_d;

  assign rise = event_i & low_seen_q;

  always_comb begin
    status_d = status_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    if (rise) begin
      snap_a_d = a_i;
      snap_b_d = b_i;
    end
    // A clear in the same cycle as an edge still drops OVERFLOW but keeps the new event.
    status_d.pending  = rise | (status_q.pending & ~clear_i);
    status_d.overflow = ~clear_i & (status_q.overflow | (rise & status_q.pending));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_seen_q <= 1'b0;
      status_q   <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
    end else begin
      low_seen_q <= ~event_i;
      status_q   <= status_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
    end
  end

  assign status_o = status_q;
  assign snap_a_o = snap_a_q;
  assign snap_b_o = snap_b_q;

endmodule

// File: rtl/mmio_game_bank.sv
// Memory-mapped register bank for targets, trajectory control, fire and PS/2
// line snapshots. Optional irq output under MMIO_GAME_BANK_IRQ_EN.
module mmio_game_bank
  import mmio_game_pkg::*;
#(
  parameter int                NUM_TARGETS = 4,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'hF00
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             bus_addr,
  input  logic [DATA_W-1:0]             bus_wdata,
  input  logic                          bus_wren,
  input  logic                          bus_rden,
  output logic [DATA_W-1:0]             bus_rdata,
  output logic                          bus_rvalid,
  input  logic                          line_ready,
  input  logic [DATA_W-1:0]             velocity_in,
  input  logic [DATA_W-1:0]             angle_in,
  output logic [NUM_TARGETS*DATA_W-1:0] target_x,
  output logic [NUM_TARGETS*DATA_W-1:0] target_y,
  output logic [DATA_W-1:0]             traj_memloc,
`ifdef MMIO_GAME_BANK_IRQ_EN
  output logic                          irq,
`endif
  output logic                          traj_enable,
  output logic                          fire
);

  localparam logic [5:0] OFS_VEL    = ofs_vel(NUM_TARGETS);
  localparam logic [5:0] OFS_ANG    = ofs_ang(NUM_TARGETS);
  localparam logic [5:0] OFS_STATUS = ofs_status(NUM_TARGETS);
  localparam logic [5:0] OFS_CTRL   = ofs_ctrl(NUM_TARGETS);
  localparam logic [5:0] OFS_TRAJ   = ofs_traj(NUM_TARGETS);

  logic              hit, wr_en, rd_en, status_clr;
  logic [5:0]        ofs;
  logic [DATA_W-1:0] tx_q [NUM_TARGETS];
  logic [DATA_W-1:0] tx_d [NUM_TARGETS];
  logic [DATA_W-1:0] ty_q [NUM_TARGETS];
  logic [DATA_W-1:0] ty_d [NUM_TARGETS];
  logic [DATA_W-1:0] traj_q, traj_d;
  logic              traj_en_q, traj_en_d;
  logic              fire_q, fire_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] ctrl_rd;
  logic [DATA_W-1:0] snap_vel, snap_ang;
  status_t           sts;

  assign hit   = (bus_addr[ADDR_W-1:6] == BASE_ADDR[ADDR_W-1:6]);
  assign ofs   = bus_addr[5:0];
  assign wr_en = bus_wren & hit;
  // A simultaneous write takes the bus; the read is dropped entirely.
  assign rd_en = bus_rden & ~bus_wren;

  mmio_event_latch #(.W(DATA_W)) u_line_evt (
    .clock    (clock),
    .reset    (reset),
    .event_i  (line_ready),
    .clear_i  (status_clr),
    .a_i      (velocity_in),
    .b_i      (angle_in),
    .status_o (sts),
    .snap_a_o (snap_vel),
    .snap_b_o (snap_ang)
  );

`ifdef MMIO_GAME_BANK_IRQ_EN
  logic irq_mask_q, irq_mask_d;
  logic irq_q;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && ofs == OFS_CTRL) irq_mask_d = bus_wdata[CTRL_IRQ_MASK];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= sts.pending & irq_mask_q;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_TRAJ] = traj_en_q;
`ifdef MMIO_GAME_BANK_IRQ_EN
    ctrl_rd[CTRL_IRQ_MASK] = irq_mask_q;
`endif
  end

  always_comb begin
    tx_d      = tx_q;
    ty_d      = ty_q;
    traj_d    = traj_q;
    traj_en_d = traj_en_q;
    fire_d    = 1'b0;
    if (wr_en) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        if (ofs == 6'(i))               tx_d[i] = bus_wdata;
        if (ofs == 6'(NUM_TARGETS + i)) ty_d[i] = bus_wdata;
      end
      if (ofs == OFS_CTRL) begin
        fire_d    = bus_wdata[CTRL_FIRE];
        traj_en_d = bus_wdata[CTRL_TRAJ];
      end
      if (ofs == OFS_TRAJ) traj_d = bus_wdata;
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    rvalid_d   = rd_en;
    status_clr = rd_en & hit & (ofs == OFS_STATUS);
    if (rd_en) begin
      rdata_d = '0;
      if (hit) begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (ofs == 6'(i))               rdata_d = tx_q[i];
          if (ofs == 6'(NUM_TARGETS + i)) rdata_d = ty_q[i];
        end
        if (ofs == OFS_VEL)    rdata_d = snap_vel;
        if (ofs == OFS_ANG)    rdata_d = snap_ang;
        if (ofs == OFS_STATUS) rdata_d = DATA_W'(sts);
        if (ofs == OFS_CTRL)   rdata_d = ctrl_rd;
        if (ofs == OFS_TRAJ)   rdata_d = traj_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        tx_q[i] <= '0;
        ty_q[i] <= '0;
      end
      traj_q    <= '0;
      traj_en_q <= 1'b0;
      fire_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      traj_q    <= traj_d;
      traj_en_q <= traj_en_d;
      fire_q    <= fire_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_tgt
    assign target_x[g*DATA_W +: DATA_W] = tx_q[g];
    assign target_y[g*DATA_W +: DATA_W] = ty_q[g];
  end

  assign traj_memloc = traj_q;
  assign traj_enable = traj_en_q;
  assign fire        = fire_q;
  assign bus_rdata   = rdata_q;
  assign bus_rvalid  = rvalid_q;

endmodule

// File: tb/tb_mmio_game_bank.sv
// Directed vector bench for mmio_game_bank (default build, N=4, base 0xF00).
module tb_mmio_game_bank;

  localparam int N = 4;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   bus_addr;
  logic [W-1:0]  bus_wdata;
  logic          bus_wren, bus_rden;
  logic [W-1:0]  bus_rdata;
  logic          bus_rvalid;
  logic          line_ready;
  logic [W-1:0]  velocity_in, angle_in;
  logic [N*W-1:0] target_x, target_y;
  logic [W-1:0]  traj_memloc;
  logic          traj_enable, fire;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  mmio_game_bank dut (
    .clock       (clock),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wren    (bus_wren),
    .bus_rden    (bus_rden),
    .bus_rdata   (bus_rdata),
    .bus_rvalid  (bus_rvalid),
    .line_ready  (line_ready),
    .velocity_in (velocity_in),
    .angle_in    (angle_in),
    .target_x    (target_x),
    .target_y    (target_y),
    .traj_memloc (traj_memloc),
    .traj_enable (traj_enable),
    .fire        (fire)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic we, input logic re, input logic [11:0] a, input logic [31:0] d);
    bus_wren  = we;
    bus_rden  = re;
    bus_addr  = a;
    bus_wdata = d;
    @(posedge clock);
    #1;
    bus_wren = 1'b0;
    bus_rden = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus_op(1'b0, 1'b1, a, 32'h0);
    check({name, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    check(name, bus_rdata, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [11:0] a,
                              input logic [31:0] d, input logic rv, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp_rvalid = rv; v.exp_rdata = rd;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    bus_addr = '0; bus_wdata = '0; bus_wren = 1'b0; bus_rden = 1'b0;
    line_ready = 1'b0; velocity_in = '0; angle_in = '0;

    for (int i = 0; i <= 2 * N + 4; i++) vecs.push_back(mk(0, 1, 12'(12'hF00 + i), 0, 1, 0));
    vecs.push_back(mk(1, 0, 12'hF02, 32'h12C,  0, 32'h0));
    vecs.push_back(mk(1, 0, 12'hF06, 32'hC8,   0, 32'h0));
    vecs.push_back(mk(0, 1, 12'hF02, 0,        1, 32'h12C));
    vecs.push_back(mk(0, 1, 12'hF06, 0,        1, 32'hC8));
    vecs.push_back(mk(1, 0, 12'hF0C, 32'hABCD, 0, 32'hC8));
    vecs.push_back(mk(0, 1, 12'hF0C, 0,        1, 32'hABCD));
    vecs.push_back(mk(1, 0, 12'hF08, 32'hDEAD, 0, 32'hABCD));
    vecs.push_back(mk(0, 1, 12'hF08, 0,        1, 32'h0));
    vecs.push_back(mk(0, 1, 12'hF0D, 0,        1, 32'h0));
    vecs.push_back(mk(0, 1, 12'hF3F, 0,        1, 32'h0));
    vecs.push_back(mk(1, 0, 12'hE02, 32'hFFFF, 0, 32'h0));
    vecs.push_back(mk(0, 1, 12'hF02, 0,        1, 32'h12C));
    vecs.push_back(mk(0, 1, 12'hEFF, 0,        1, 32'h0));
    vecs.push_back(mk(1, 1, 12'hF03, 32'h55,   0, 32'h0));
    vecs.push_back(mk(0, 1, 12'hF03, 0,        1, 32'h55));
    vecs.push_back(mk(0, 0, 12'hF03, 0,        0, 32'h55));
    vecs.push_back(mk(1, 0, 12'hF0B, 32'h0,    0, 32'h55));
    vecs.push_back(mk(0, 1, 12'hF0B, 0,        1, 32'h0));

    idle(2);
    reset = 1'b0;
    idle(1);
    check("reset_fire",   32'(fire), 0);
    check("reset_traj",   32'(traj_enable), 0);
    check("reset_rvalid", 32'(bus_rvalid), 0);
    check("reset_rdata",  bus_rdata, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus_op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rvalid", i), 32'(bus_rvalid), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
      if (i == 2 * N + 5) check("tx2_after_write", target_x[95:64], 32'h12C);
      if (i == 2 * N + 6) check("ty2_after_write", target_y[95:64], 32'hC8);
    end
    check("target_x2", target_x[95:64], 32'h12C);
    check("target_y2", target_y[95:64], 32'hC8);
    check("target_x3", target_x[127:96], 32'h55);
    check("traj_memloc", traj_memloc, 32'hABCD);

    // fire pulse and trajectory enable
    bus_op(1'b1, 1'b0, 12'hF0B, 32'h3);
    check("fire_pulse", 32'(fire), 1);
    check("traj_en_set", 32'(traj_enable), 1);
    idle(1);
    check("fire_one_cycle", 32'(fire), 0);
    check("traj_en_holds", 32'(traj_enable), 1);
    rd_check("ctrl_read", 12'hF0B, 32'h2);
    bus_op(1'b1, 1'b0, 12'hF0B, 32'h1);
    check("fire_b2b_1", 32'(fire), 1);
    bus_op(1'b1, 1'b0, 12'hF0B, 32'h1);
    check("fire_b2b_2", 32'(fire), 1);
    check("traj_en_clr", 32'(traj_enable), 0);
    idle(1);
    check("fire_b2b_end", 32'(fire), 0);

    // single event with line_ready held high
    velocity_in = 25; angle_in = 45; line_ready = 1'b1;
    idle(5);
    line_ready = 1'b0;
    idle(1);
    rd_check("sts_single", 12'hF0A, 32'h1);
    rd_check("vel_single", 12'hF08, 32'd25);
    rd_check("ang_single", 12'hF09, 32'd45);
    rd_check("sts_cleared", 12'hF0A, 32'h0);

    // two events before a read -> overflow, newest snapshot wins
    velocity_in = 10; line_ready = 1'b1; idle(2);
    line_ready = 1'b0; idle(2);
    velocity_in = 20; line_ready = 1'b1; idle(2);
    line_ready = 1'b0; idle(1);
    rd_check("sts_overflow", 12'hF0A, 32'h3);
    rd_check("vel_newest", 12'hF08, 32'd20);
    rd_check("sts_ovf_cleared", 12'hF0A, 32'h0);

    // edge coincident with a STATUS read while pending
    velocity_in = 30; line_ready = 1'b1; idle(1);
    line_ready = 1'b0; idle(1);
    velocity_in = 40; line_ready = 1'b1;
    rd_check("sts_coincident", 12'hF0A, 32'h1);
    line_ready = 1'b0;
    rd_check("sts_after_coinc", 12'hF0A, 32'h1);
    rd_check("vel_after_coinc", 12'hF08, 32'd40);
    rd_check("sts_coinc_clr", 12'hF0A, 32'h0);

    // reset mid-operation: fire cancelled, no retrigger from held line_ready
    bus_op(1'b1, 1'b0, 12'hF0B, 32'h1);
    check("fire_before_rst", 32'(fire), 1);
    velocity_in = 77; line_ready = 1'b1; reset = 1'b1;
    #1;
    check("fire_cancelled", 32'(fire), 0);
    check("tx_cleared", target_x[95:64], 0);
    idle(2);
    reset = 1'b0;
    idle(3);
    rd_check("sts_no_retrigger", 12'hF0A, 32'h0);
    rd_check("vel_lost", 12'hF08, 32'h0);
    line_ready = 1'b0; idle(1);
    line_ready = 1'b1; idle(1);
    line_ready = 1'b0;
    rd_check("sts_rearmed", 12'hF0A, 32'h1);
    rd_check("vel_rearmed", 12'hF08, 32'd77);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
